// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO: synchronised (optionally debounced) switch inputs with sticky rising-edge flags,
// plus an LED output register. Define GPIO_DEBOUNCE_EN to build the per-bit debounce counters.
module gpio_mmio #(
   parameter int IN_W       = 8,
   parameter int OUT_W      = 9,
   parameter int DEB_CYCLES = 500000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel,
   input  logic             we,
   input  logic [3:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   input  logic [IN_W-1:0]  gpio_i,
   output logic [OUT_W-1:0] gpio_o,
   output logic             irq
);

   typedef enum logic [1:0] {
      REG_OUT    = 2'd0,
      REG_IN     = 2'd1,
      REG_EDGE   = 2'd2,
      REG_TOGGLE = 2'd3
   } reg_e;

   if (DEB_CYCLES < 2) begin : g_deb_range_check
      $error("gpio_mmio: DEB_CYCLES must be at least 2");
   end

   reg_e             reg_sel;
   logic             wr_en;
   logic [OUT_W-1:0] out_q;
   logic [IN_W-1:0]  s1;
   logic [IN_W-1:0]  s2;
   logic [IN_W-1:0]  stable;
   logic [IN_W-1:0]  stable_nxt;
   logic [IN_W-1:0]  rise;
   logic [IN_W-1:0]  w1c;
   logic [IN_W-1:0]  edge_flags;
   logic             unused_bits;

   assign reg_sel     = reg_e'(addr[3:2]);
   assign wr_en       = sel & we;
   // Byte-lane bits of addr and the upper wdata bits carry no meaning here.
   assign unused_bits = ^{addr[1:0], wdata};

   // Two-flop synchroniser for the raw pins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         // NOTE: non-blocking assignments make s2 take the old s1, giving a true two-stage chain.
         s1 <= gpio_i;
         s2 <= s1;
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   localparam int               CNT_W    = $clog2(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [CNT_W-1:0] cnt [IN_W];

   always_comb begin
      stable_nxt = stable;
      for (int i = 0; i < IN_W; i++) begin
         if ((s2[i] != stable[i]) && (cnt[i] == CNT_LAST)) begin
            stable_nxt[i] = s2[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable <= '0;
         // NOTE: the counter array is reset explicitly so a reset mid-debounce discards partial counts.
         for (int i = 0; i < IN_W; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         stable <= stable_nxt;
         for (int i = 0; i < IN_W; i++) begin
            if (s2[i] != stable[i]) begin
               cnt[i] <= (cnt[i] == CNT_LAST) ? '0 : cnt[i] + 1'b1;
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end
`else
   // Without debouncing the second synchroniser stage is the stable value; s1 is its next value.
   assign stable     = s2;
   assign stable_nxt = s1;
`endif

   // A bit rises on the edge where its stable value goes 0 -> 1.
   assign rise = stable_nxt & ~stable;
   assign w1c  = (wr_en && (reg_sel == REG_EDGE)) ? wdata[IN_W-1:0] : '0;

   // Set is OR-ed in after the clear so a simultaneous set wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         edge_flags <= '0;
      end else begin
         edge_flags <= (edge_flags & ~w1c) | rise;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
      end else if (wr_en) begin
         case (reg_sel)
            REG_OUT:    out_q <= wdata[OUT_W-1:0];
            REG_TOGGLE: out_q <= out_q ^ wdata[OUT_W-1:0];
            default:    out_q <= out_q;
         endcase
      end
   end

   always_comb begin
      // NOTE: default first so every path assigns rdata and no latch is inferred.
      rdata = '0;
      if (sel) begin
         case (reg_sel)
            REG_OUT:    rdata[OUT_W-1:0] = out_q;
            REG_IN:     rdata[IN_W-1:0]  = stable;
            REG_EDGE:   rdata[IN_W-1:0]  = edge_flags;
            default:    rdata            = '0;
         endcase
      end
   end

   assign gpio_o = out_q;
   assign irq    = |edge_flags;

endmodule

// File: tb/tb_gpio_mmio.sv
// Directed bench for gpio_mmio with DEB_CYCLES=4; input latency follows GPIO_DEBOUNCE_EN.
module tb_gpio_mmio;

   localparam int IN_W  = 8;
   localparam int OUT_W = 9;
`ifdef GPIO_DEBOUNCE_EN
   localparam int LAT = 6;
`else
   localparam int LAT = 2;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             sel;
   logic             we;
   logic [3:0]       addr;
   logic [31:0]      wdata;
   logic [31:0]      rdata;
   logic [IN_W-1:0]  gpio_i;
   logic [OUT_W-1:0] gpio_o;
   logic             irq;

   int checks   = 0;
   int failures = 0;

   gpio_mmio #(
      .IN_W       (IN_W),
      .OUT_W      (OUT_W),
      .DEB_CYCLES (4)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .sel    (sel),
      .we     (we),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata),
      .gpio_i (gpio_i),
      .gpio_o (gpio_o),
      .irq    (irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      sel   = 1'b1;
      we    = 1'b1;
      addr  = a;
      wdata = d;
      tick();
      sel   = 1'b0;
      we    = 1'b0;
      wdata = '0;
   endtask

   task automatic check_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
      sel  = 1'b1;
      we   = 1'b0;
      addr = a;
      #1;
      check(tag, rdata, exp);
      sel  = 1'b0;
   endtask

   initial begin
      rst    = 1'b1;
      sel    = 1'b0;
      we     = 1'b0;
      addr   = '0;
      wdata  = '0;
      gpio_i = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;

      // Reset release
      check("rst_gpio_o", 32'(gpio_o), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check_read("rst_rd_out", 4'h0, 32'h0);
      check_read("rst_rd_in", 4'h4, 32'h0);
      check_read("rst_rd_edge", 4'h8, 32'h0);
      check_read("rst_rd_tog", 4'hC, 32'h0);

      // OUT write, toggle, readback; writes to IN ignored
      bus_write(4'h0, 32'h0000_01A5);
      check("wr_out_gpio_o", 32'(gpio_o), 32'h1A5);
      bus_write(4'hC, 32'h0000_00FF);
      check("tog_gpio_o", 32'(gpio_o), 32'h15A);
      check_read("rd_out", 4'h0, 32'h0000_015A);
      check_read("rd_tog_zero", 4'hC, 32'h0);
      addr = 4'h0;
      #1;
      check("rdata_idle", rdata, 32'h0);
      bus_write(4'h4, 32'hFFFF_FFFF);
      check_read("rd_in_after_wr", 4'h4, 32'h0);
      check_read("rd_out_after_in_wr", 4'h0, 32'h0000_015A);
      bus_write(4'h3, 32'h0000_0003);
      check("addr_low_ignored", 32'(gpio_o), 32'h003);
      bus_write(4'h0, 32'h0000_015A);

      // Debounce accept: exact latency
      gpio_i = 8'h81;
      repeat (LAT - 1) tick();
      check_read("acc_in_early", 4'h4, 32'h0);
      check_read("acc_edge_early", 4'h8, 32'h0);
      check("acc_irq_early", 32'(irq), 32'h0);
      tick();
      check_read("acc_in", 4'h4, 32'h81);
      check_read("acc_edge", 4'h8, 32'h81);
      check("acc_irq", 32'(irq), 32'h1);

      // W1C clear, then falling inputs set no flag
      bus_write(4'h8, 32'h0000_0001);
      check_read("w1c_partial", 4'h8, 32'h80);
      bus_write(4'h8, 32'h0000_0080);
      check("w1c_irq", 32'(irq), 32'h0);
      gpio_i = 8'h00;
      repeat (LAT + 2) tick();
      check_read("fall_in", 4'h4, 32'h0);
      check_read("fall_edge", 4'h8, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
      // Glitch reject (3-cycle pulse), then 4-cycle pulse accepted
      gpio_i = 8'h08;
      repeat (3) tick();
      gpio_i = 8'h00;
      repeat (8) tick();
      check_read("glitch_in", 4'h4, 32'h0);
      check_read("glitch_edge", 4'h8, 32'h0);
      gpio_i = 8'h08;
      repeat (4) tick();
      gpio_i = 8'h00;
      repeat (10) tick();
      check_read("pulse4_edge", 4'h8, 32'h08);
      check_read("pulse4_in_back", 4'h4, 32'h0);
      bus_write(4'h8, 32'h0000_0008);
`endif

      // W1C versus set collision
      gpio_i = 8'h01;
      repeat (LAT) tick();
      check_read("coll_pre_edge", 4'h8, 32'h01);
      gpio_i = 8'h03;
      repeat (LAT - 1) tick();
      bus_write(4'h8, 32'h0000_0003);
      check_read("coll_edge", 4'h8, 32'h02);
      check("coll_irq", 32'(irq), 32'h1);
      check_read("coll_in", 4'h4, 32'h03);
      gpio_i = 8'h00;
      repeat (LAT + 2) tick();
      bus_write(4'h8, 32'h0000_00FF);
      check_read("coll_cleared", 4'h8, 32'h0);

      // Async reset mid-debounce (cnt = 2 when debouncing)
      gpio_i = 8'h40;
      repeat (4) tick();
      rst = 1'b1;
      #1;
      check("arst_gpio_o", 32'(gpio_o), 32'h0);
      check("arst_irq", 32'(irq), 32'h0);
      check_read("arst_rd_out", 4'h0, 32'h0);
      tick();
      rst = 1'b0;
      repeat (LAT - 1) tick();
      check_read("arst_in_early", 4'h4, 32'h0);
      tick();
      check_read("arst_in", 4'h4, 32'h40);
      check_read("arst_edge", 4'h8, 32'h40);
      check("arst_irq_set", 32'(irq), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
